// File: rtl/spi_arb_pkg.sv
// Shared definitions for the housekeeping SPI host arbiter: FSM state
// encoding, master index constants, counter types and default parameters.
// Optional watchdog is enabled with the macro SPI_ARB_WATCHDOG_EN.
package spi_arb_pkg;

    // LOCK is only reachable when the hold watchdog is built in.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_GAP  = 2'd2,
        ST_LOCK = 2'd3
    } arb_state_e;

    // Master indices: 0 is the UART-to-SPI bridge, 1 the management master.
    localparam logic M_UART = 1'b0;
    localparam logic M_MGMT = 1'b1;

    localparam int GAP_CYCLES_DEF = 4;
    localparam int MAX_HOLD_DEF   = 200000;

    typedef logic [7:0]  gap_cnt_t;
    typedef logic [23:0] hold_cnt_t;

endpackage

// File: rtl/spi_arb_hold_wdog.sv
// Hold watchdog for the current bus owner: detects SCK edges and counts the
// clk cycles between them with a saturating 24-bit counter. expire_o pulses
// on the cycle the owner has gone MAX_HOLD cycles without an SCK edge.
// Instantiated by spi_host_arbiter only when SPI_ARB_WATCHDOG_EN is defined.
module spi_arb_hold_wdog
    import spi_arb_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,      // high while a master owns the bus
    input  logic sck_i,     // owner's SCK as seen at the arbiter input
    output logic expire_o
);

    localparam hold_cnt_t HOLD_LAST = hold_cnt_t'(MAX_HOLD - 1);

    logic      sck_prev_q;
    hold_cnt_t hold_cnt_q;
    logic      sck_edge;

    // Ownership always starts with SCK low, so the edge history restarts at 0.
    assign sck_edge = en_i && (sck_i != sck_prev_q);
    assign expire_o = en_i && !sck_edge && (hold_cnt_q >= HOLD_LAST);

    // Track the previous owner SCK level and count quiet cycles, saturating.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_prev_q <= 1'b0;
            hold_cnt_q <= '0;
        end else begin
            sck_prev_q <= en_i ? sck_i : 1'b0;
            if (!en_i || sck_edge) begin
                hold_cnt_q <= '0;
            end else if (hold_cnt_q != '1) begin
                hold_cnt_q <= hold_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_host_arbiter.sv
// Two-master arbiter for the Caravel housekeeping SPI bus. Ownership is
// granted per CSB-low window with round-robin on simultaneous requests, the
// bus is a registered copy of the owner's pins, and every release is
// followed by a fixed CSB-high gap. Define SPI_ARB_WATCHDOG_EN to add the
// SCK-inactivity watchdog and the LOCK state.
module spi_host_arbiter
    import spi_arb_pkg::*;
#(
    parameter int GAP_CYCLES = GAP_CYCLES_DEF,
    parameter int MAX_HOLD   = MAX_HOLD_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       m0_csb,
    input  logic       m0_sck,
    input  logic       m0_sdi,
    output logic       m0_sdo,
    output logic       m0_gnt,
    input  logic       m1_csb,
    input  logic       m1_sck,
    input  logic       m1_sdi,
    output logic       m1_sdo,
    output logic       m1_gnt,
    output logic       spi_csb,
    output logic       spi_sck,
    output logic       spi_sdi,
    input  logic       spi_sdo,
    output logic       busy,
    output logic [1:0] timeout
);

    localparam gap_cnt_t GAP_LAST = gap_cnt_t'(GAP_CYCLES - 1);

    arb_state_e state_q;
    logic       owner_q;
    logic       last_q;
    logic [1:0] gnt_q;
    logic       spi_csb_q;
    logic       spi_sck_q;
    logic       spi_sdi_q;
    gap_cnt_t   gap_cnt_q;

    logic [1:0] csb_vec;
    logic [1:0] sck_vec;
    logic [1:0] sdi_vec;
    logic [1:0] req_vec;
    logic [1:0] sdo_vec;
    logic       grant_idx;
    logic       own_csb;
    logic       own_sck;
    logic       own_sdi;

    assign csb_vec = {m1_csb, m0_csb};
    assign sck_vec = {m1_sck, m0_sck};
    assign sdi_vec = {m1_sdi, m0_sdi};

    // A request needs CSB low with SCK idle low; only the owner sees device data.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_master
            assign req_vec[gi] = ~csb_vec[gi] & ~sck_vec[gi];
            assign sdo_vec[gi] = gnt_q[gi] & spi_sdo;
        end
    endgenerate

    assign m0_sdo  = sdo_vec[M_UART];
    assign m1_sdo  = sdo_vec[M_MGMT];
    assign m0_gnt  = gnt_q[M_UART];
    assign m1_gnt  = gnt_q[M_MGMT];
    assign spi_csb = spi_csb_q;
    assign spi_sck = spi_sck_q;
    assign spi_sdi = spi_sdi_q;
    assign busy    = (state_q != ST_IDLE);

    // Pick the winner of the current requests and select the owner's pins.
    always_comb begin
        grant_idx = (req_vec == 2'b11) ? ~last_q : req_vec[M_MGMT];
        own_csb   = csb_vec[owner_q];
        own_sck   = sck_vec[owner_q];
        own_sdi   = sdi_vec[owner_q];
    end

`ifdef SPI_ARB_WATCHDOG_EN
    logic       wd_expire;
    logic [1:0] timeout_q;

    spi_arb_hold_wdog #(
        .MAX_HOLD (MAX_HOLD)
    ) u_hold_wdog (
        .clk      (clk),
        .reset    (reset),
        .en_i     (state_q == ST_OWN),
        .sck_i    (own_sck),
        .expire_o (wd_expire)
    );

    assign timeout = timeout_q;
`else
    logic unused_max_hold;
    assign unused_max_hold = ^MAX_HOLD;
    assign timeout         = 2'b00;
`endif

    // Arbiter FSM with registered grant and bus outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            owner_q   <= M_UART;
            last_q    <= M_MGMT;
            gnt_q     <= 2'b00;
            spi_csb_q <= 1'b1;
            spi_sck_q <= 1'b0;
            spi_sdi_q <= 1'b0;
            gap_cnt_q <= '0;
`ifdef SPI_ARB_WATCHDOG_EN
            timeout_q <= 2'b00;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Bus stays idle on the grant edge; CSB follows one edge later.
                    if (|req_vec) begin
                        owner_q <= grant_idx;
                        last_q  <= grant_idx;
                        gnt_q   <= {grant_idx, ~grant_idx};
                        state_q <= ST_OWN;
                    end
                end
                ST_OWN: begin
                    if (own_csb) begin
                        spi_csb_q <= 1'b1;
                        spi_sck_q <= 1'b0;
                        spi_sdi_q <= 1'b0;
                        gnt_q     <= 2'b00;
                        gap_cnt_q <= '0;
                        state_q   <= ST_GAP;
`ifdef SPI_ARB_WATCHDOG_EN
                    end else if (wd_expire) begin
                        spi_csb_q          <= 1'b1;
                        spi_sck_q          <= 1'b0;
                        spi_sdi_q          <= 1'b0;
                        gnt_q              <= 2'b00;
                        timeout_q[owner_q] <= 1'b1;
                        state_q            <= ST_LOCK;
`endif
                    end else begin
                        spi_csb_q <= own_csb;
                        spi_sck_q <= own_sck;
                        spi_sdi_q <= own_sdi;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q >= GAP_LAST) begin
                        state_q <= ST_IDLE;
                    end else if (gap_cnt_q != '1) begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
`ifdef SPI_ARB_WATCHDOG_EN
                ST_LOCK: begin
                    // Timed-out master must cycle CSB high before anyone is served.
                    if (own_csb) begin
                        gap_cnt_q <= '0;
                        state_q   <= ST_GAP;
                    end
                end
`endif
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_host_arbiter.sv
// Self-checking bench for spi_host_arbiter. A transaction-level reference
// model (owner, earliest next arbitration edge, round-robin last winner)
// predicts every output after every clk edge. Directed steps cover the
// single transfer, round robin, requests during the gap, data return,
// async reset and, with SPI_ARB_WATCHDOG_EN, the watchdog lock; a random
// section then runs both masters against the same model.
module tb_spi_host_arbiter;

    localparam int GAP = 4;
`ifdef SPI_ARB_WATCHDOG_EN
    localparam int HOLD = 100;
`else
    localparam int HOLD = 200000;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] csb_b = 2'b11;
    logic [1:0] sck_b = 2'b00;
    logic [1:0] sdi_b = 2'b00;
    logic       spi_sdo_b = 1'b0;

    logic       m0_sdo, m0_gnt, m1_sdo, m1_gnt;
    logic       spi_csb, spi_sck, spi_sdi, busy;
    logic [1:0] timeout;

    always #5 clk = ~clk;

    spi_host_arbiter #(
        .GAP_CYCLES (GAP),
        .MAX_HOLD   (HOLD)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .m0_csb  (csb_b[0]),
        .m0_sck  (sck_b[0]),
        .m0_sdi  (sdi_b[0]),
        .m0_sdo  (m0_sdo),
        .m0_gnt  (m0_gnt),
        .m1_csb  (csb_b[1]),
        .m1_sck  (sck_b[1]),
        .m1_sdi  (sdi_b[1]),
        .m1_sdo  (m1_sdo),
        .m1_gnt  (m1_gnt),
        .spi_csb (spi_csb),
        .spi_sck (spi_sck),
        .spi_sdi (spi_sdi),
        .spi_sdo (spi_sdo_b),
        .busy    (busy),
        .timeout (timeout)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state, expressed in edge numbers rather than FSM states.
    int         t_now = 0;
    int         owner_m = -1;
    int         lock_m = -1;
    int         next_arb = 1;
    int         last_m = 1;
    int         hold_since = 0;
    logic       prev_sck = 1'b0;
    logic [1:0] exp_to = 2'b00;
    logic [1:0] exp_gnt = 2'b00;
    logic       exp_csb = 1'b1;
    logic       exp_sck = 1'b0;
    logic       exp_sdi = 1'b0;
    logic       exp_busy = 1'b0;

    // Random master driver state.
    int ph[2];
    int pulses[2];
    int idle_left[2];

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        owner_m  = -1;
        lock_m   = -1;
        next_arb = t_now + 1;
        last_m   = 1;
        exp_to   = 2'b00;
        exp_gnt  = 2'b00;
        exp_csb  = 1'b1;
        exp_sck  = 1'b0;
        exp_sdi  = 1'b0;
        exp_busy = 1'b0;
    endtask

    // Apply one clk edge of the specification's rules to the model.
    task automatic model_edge();
        logic [1:0] req;
        logic       mirror;
        t_now++;
        mirror = 1'b0;
        if (owner_m >= 0) begin
            if (csb_b[owner_m]) begin
                owner_m  = -1;
                next_arb = t_now + GAP + 1;
`ifdef SPI_ARB_WATCHDOG_EN
            end else if (sck_b[owner_m] != prev_sck) begin
                hold_since = t_now;
                prev_sck   = sck_b[owner_m];
                mirror     = 1'b1;
            end else if (t_now - hold_since >= HOLD) begin
                exp_to[owner_m] = 1'b1;
                lock_m  = owner_m;
                owner_m = -1;
`endif
            end else begin
                mirror = 1'b1;
            end
        end else if (lock_m >= 0) begin
            if (csb_b[lock_m]) begin
                lock_m   = -1;
                next_arb = t_now + GAP + 1;
            end
        end else if (t_now >= next_arb) begin
            req = ~csb_b & ~sck_b;
            if (req != 2'b00) begin
                owner_m    = (req == 2'b11) ? (1 - last_m) : (req[1] ? 1 : 0);
                last_m     = owner_m;
                hold_since = t_now;
                prev_sck   = 1'b0;
            end
        end
        if (mirror) begin
            exp_csb = 1'b0;
            exp_sck = sck_b[owner_m];
            exp_sdi = sdi_b[owner_m];
        end else begin
            exp_csb = 1'b1;
            exp_sck = 1'b0;
            exp_sdi = 1'b0;
        end
        exp_gnt  = (owner_m == 0) ? 2'b01 : ((owner_m == 1) ? 2'b10 : 2'b00);
        exp_busy = (owner_m >= 0) || (lock_m >= 0) || (t_now < next_arb - 1);
    endtask

    task automatic check_all(input string tag);
        logic [9:0] obs;
        logic [9:0] exp;
        obs = {m1_gnt, m0_gnt, spi_csb, spi_sck, spi_sdi, busy, m1_sdo, m0_sdo, timeout};
        exp = {exp_gnt, exp_csb, exp_sck, exp_sdi, exp_busy, exp_gnt & {2{spi_sdo_b}}, exp_to};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s edge=%0d observed=%b expected=%b (gnt csb sck sdi busy sdo timeout)",
                   tag, t_now, obs, exp);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        #1;
        model_edge();
        check_all(tag);
    endtask

    task automatic do_reset();
        csb_b = 2'b11;
        sck_b = 2'b00;
        sdi_b = 2'b00;
        spi_sdo_b = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_all("reset_state");
        reset = 1'b0;
    endtask

    // Tick until master n is granted or the bound expires; edges = ticks used.
    task automatic wait_gnt(input int n, input int limit, input string tag, output int edges);
        edges = 0;
        while (!(n == 1 ? m1_gnt : m0_gnt) && edges < limit) begin
            tick(tag);
            edges++;
        end
        chk1({tag, "_granted"}, (n == 1 ? m1_gnt : m0_gnt), 1'b1);
    endtask

    // Master n: clock out k SCK pulses with random data.
    task automatic pulses_n(input int n, input int k, input string tag);
        for (int i = 0; i < k; i++) begin
            sck_b[n] = 1'b1;
            tick(tag);
            sck_b[n] = 1'b0;
            sdi_b[n] = 1'($urandom);
            tick(tag);
        end
    endtask

    task automatic drive_rand();
        logic [1:0] g;
        g = {m1_gnt, m0_gnt};
        for (int n = 0; n < 2; n++) begin
            case (ph[n])
                0: begin
                    if (idle_left[n] > 0) begin
                        idle_left[n]--;
                    end else begin
                        csb_b[n] = 1'b0;
                        sck_b[n] = 1'b0;
                        sdi_b[n] = 1'($urandom);
                        ph[n]    = 1;
                    end
                end
                1: begin
                    if (g[n]) begin
                        ph[n]     = 2;
                        pulses[n] = int'($urandom_range(1, 5));
                        sck_b[n]  = 1'b1;
                    end
                end
                default: begin
                    if (sck_b[n]) begin
                        sck_b[n] = 1'b0;
                        sdi_b[n] = 1'($urandom);
                        pulses[n]--;
                    end else if (pulses[n] == 0) begin
                        csb_b[n]     = 1'b1;
                        sdi_b[n]     = 1'b0;
                        ph[n]        = 0;
                        idle_left[n] = int'($urandom_range(0, 6));
                        $display("txn: master %0d released at edge %0d", n, t_now);
                    end else begin
                        sck_b[n] = 1'b1;
                    end
                end
            endcase
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit reached edge=%0d", t_now);
        $fatal(1, "time limit");
    end

    initial begin
        int edges;

        // Test 1: single m0 transfer, mirrored bus, gap after release.
        do_reset();
        $display("step: m0 single transfer");
        csb_b[0] = 1'b0;
        tick("t1_grant");
        chk1("t1_gnt0", m0_gnt, 1'b1);
        chk1("t1_csb_high_on_grant", spi_csb, 1'b1);
        tick("t1_csb_low");
        chk1("t1_csb_low", spi_csb, 1'b0);
        pulses_n(0, 8, "t1_xfer");
        csb_b[0] = 1'b1;
        tick("t1_release");
        chk1("t1_gnt_drop", m0_gnt, 1'b0);
        repeat (GAP - 1) tick("t1_gap");
        chk1("t1_busy_last_gap", busy, 1'b1);
        tick("t1_idle");
        chk1("t1_idle", busy, 1'b0);

        // Test 2 + 4: simultaneous requests after reset, m1 gets data.
        do_reset();
        $display("step: simultaneous requests after reset");
        csb_b = 2'b00;
        tick("t2_both");
        chki("t2_first_gnt", int'({m1_gnt, m0_gnt}), 1);
        pulses_n(0, 2, "t2_m0_xfer");
        csb_b[0] = 1'b1;
        tick("t2_m0_release");
        wait_gnt(1, 20, "t2_m1_wait", edges);
        chki("t2_gap_len", edges, GAP + 1);
        $display("step: device data to m1");
        spi_sdo_b = 1'b1;
        pulses_n(1, 3, "t4_m1_xfer");
        chk1("t4_m1_sdo", m1_sdo, 1'b1);
        chk1("t4_m0_sdo", m0_sdo, 1'b0);
        csb_b[1] = 1'b1;
        spi_sdo_b = 1'b0;
        tick("t4_m1_release");
        repeat (GAP) tick("t4_gap");
        csb_b = 2'b00;
        tick("t2_repeat_both");
        chki("t2_second_gnt", int'({m1_gnt, m0_gnt}), 1);
        pulses_n(0, 1, "t2_m0_xfer2");
        csb_b[0] = 1'b1;
        tick("t2_m0_release2");
        wait_gnt(1, 20, "t2_m1_wait2", edges);
        csb_b[1] = 1'b1;
        tick("t2_m1_release2");
        repeat (GAP) tick("t2_gap2");

        // Test 3: m1 requests in the middle of m0's gap.
        $display("step: request during gap");
        csb_b[0] = 1'b0;
        tick("t3_grant_m0");
        pulses_n(0, 2, "t3_m0_xfer");
        csb_b[0] = 1'b1;
        tick("t3_release");
        tick("t3_gap1");
        csb_b[1] = 1'b0;
        wait_gnt(1, 20, "t3_m1_wait", edges);
        chki("t3_grant_delay", edges, GAP);
        pulses_n(1, 1, "t3_m1_xfer");
        csb_b[1] = 1'b1;
        tick("t3_m1_release");
        repeat (GAP) tick("t3_gap");

        // Test 5: async reset with SCK high, then immediate grant.
        $display("step: async reset mid-transfer");
        csb_b[0] = 1'b0;
        tick("t5_grant");
        sck_b[0] = 1'b1;
        tick("t5_csb_low");
        tick("t5_sck_high");
        chk1("t5_sck_high", spi_sck, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("t5_async_reset");
        chk1("t5_async_csb", spi_csb, 1'b1);
        chk1("t5_async_sck", spi_sck, 1'b0);
        csb_b = 2'b00;
        sck_b = 2'b00;
        #1;
        reset = 1'b0;
        tick("t5_post_reset");
        chki("t5_post_reset_gnt", int'({m1_gnt, m0_gnt}), 1);

        // Random section: two autonomous masters against the model.
        do_reset();
        $display("step: random traffic");
        for (int n = 0; n < 2; n++) begin
            ph[n] = 0;
            pulses[n] = 0;
            idle_left[n] = int'($urandom_range(0, 3));
        end
        for (int c = 0; c < 600; c++) begin
            drive_rand();
            spi_sdo_b = 1'($urandom);
            tick("rnd");
        end

`ifdef SPI_ARB_WATCHDOG_EN
        // Test 6: m0 stalls with no SCK, watchdog locks it out.
        do_reset();
        $display("step: watchdog expiry");
        csb_b[0] = 1'b0;
        tick("t6_grant");
        csb_b[1] = 1'b0;
        repeat (HOLD - 1) tick("t6_hold");
        chk1("t6_still_owned", spi_csb, 1'b0);
        tick("t6_expire");
        chk1("t6_csb_forced", spi_csb, 1'b1);
        chki("t6_timeout", int'(timeout), 1);
        repeat (10) tick("t6_lock");
        chki("t6_m1_blocked", int'({m1_gnt, m0_gnt}), 0);
        csb_b[0] = 1'b1;
        tick("t6_unlock");
        wait_gnt(1, 20, "t6_m1_wait", edges);
        chki("t6_gap_len", edges, GAP + 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
